// File: rtl/draw_rect_sched_pkg.sv
// Shared types for the rectangle-fill scheduler.
//   DEF_COORD_W   default signed coordinate/size width
//   PIX_ID_W      requester-id field width in pix_t (covers NREQ up to 8)
//   sched_state_t scheduler FSM states
//   rect_cmd_t    latched draw operands {x, y, h, w}
//   pix_t         buffered pixel {x, y, id}
package draw_rect_sched_pkg;

  localparam int unsigned DEF_COORD_W = 32;
  localparam int unsigned PIX_ID_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } sched_state_t;

  typedef struct packed {
    logic signed [DEF_COORD_W-1:0] x;
    logic signed [DEF_COORD_W-1:0] y;
    logic signed [DEF_COORD_W-1:0] h;
    logic signed [DEF_COORD_W-1:0] w;
  } rect_cmd_t;

  typedef struct packed {
    logic signed [DEF_COORD_W-1:0] x;
    logic signed [DEF_COORD_W-1:0] y;
    logic [PIX_ID_W-1:0]           id;
  } pix_t;

endpackage

// File: rtl/draw_rect_sched_skid.sv
// Two-entry skid buffer carrying pixels from the fill engine to the
// framebuffer writer.
//   _clock, _reset_n  clock, async active-low reset
//   push, push_data   write one pixel (ignored when full)
//   pop               consume head pixel (ignored when empty)
//   head              oldest stored pixel, stable until popped
//   full, empty       occupancy flags
module draw_rect_sched_skid
  import draw_rect_sched_pkg::*;
(
  input  logic _clock,
  input  logic _reset_n,
  input  logic push,
  input  pix_t push_data,
  input  logic pop,
  output pix_t head,
  output logic full,
  output logic empty
);

  pix_t       mem_q [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = mem_q[rd_q];
  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/draw_rect_scheduler.sv
// Shares one rectangle-fill engine between NREQ requesters with round-robin
// arbitration, forwards the engine's coordinate stream through a skid buffer
// and pulses req_done to the owner when the job has fully drained.
//   req_valid/req_ready/req_done   per-requester command handshake + completion
//   req_x/y/h/w                    per-requester signed operands
//   eng_start, eng_x/y/h/w          engine launch and latched operands
//   eng_valid/eng_ready, eng_out0/1 engine coordinate stream
//   eng_done                        engine finished (level)
//   pix_valid/pix_ready, pix_x/y/id pixel stream to the framebuffer writer
//   err                             sticky pixel-count mismatch
// Optional: define DRAW_RECT_SCHED_PIXCHECK_EN to count pixels per job and
// flag a count that differs from w*h; otherwise err is tied low.
module draw_rect_scheduler
  import draw_rect_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned COORD_W = DEF_COORD_W
) (
  input  logic                             _clock,
  input  logic                             _reset_n,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ-1:0][COORD_W-1:0]     req_x,
  input  logic [NREQ-1:0][COORD_W-1:0]     req_y,
  input  logic [NREQ-1:0][COORD_W-1:0]     req_h,
  input  logic [NREQ-1:0][COORD_W-1:0]     req_w,
  output logic [NREQ-1:0]                  req_done,
  output logic                             eng_start,
  output logic signed [COORD_W-1:0]        eng_x,
  output logic signed [COORD_W-1:0]        eng_y,
  output logic signed [COORD_W-1:0]        eng_h,
  output logic signed [COORD_W-1:0]        eng_w,
  input  logic                             eng_valid,
  output logic                             eng_ready,
  input  logic signed [COORD_W-1:0]        eng_out0,
  input  logic signed [COORD_W-1:0]        eng_out1,
  input  logic                             eng_done,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic signed [COORD_W-1:0]        pix_x,
  output logic signed [COORD_W-1:0]        pix_y,
  output logic [$clog2(NREQ)-1:0]          pix_id,
  output logic                             err
);

  localparam int unsigned ID_W = $clog2(NREQ);
  localparam logic signed [COORD_W-1:0] ZERO = '0;

  sched_state_t    state_q, state_d;
  logic [ID_W-1:0] g_q, g_d;
  logic [ID_W-1:0] rr_q;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] idx;
  logic            found;
  rect_cmd_t       cmd_q;
  logic            push;
  logic            pop;
  logic            skid_full;
  logic            skid_empty;
  pix_t            push_data;
  pix_t            head;

  // First pending requester at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = ID_W'((32'(rr_q) + i) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    req_ready = '0;
    req_done  = '0;
    eng_start = 1'b0;
    push      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          g_d     = pick;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        req_ready[g_q] = 1'b1;
        if ($signed(req_w[g_q]) <= ZERO || $signed(req_h[g_q]) <= ZERO) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        eng_start = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        push = eng_valid && eng_ready;
        // A valid pixel stalled by a full buffer must still be taken before
        // leaving RUN, so done only counts once that pixel is accepted.
        if (eng_done && !(eng_valid && !eng_ready)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (skid_empty) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        req_done[g_q] = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      if (state_q == ST_GRANT) begin
        cmd_q.x <= req_x[g_q];
        cmd_q.y <= req_y[g_q];
        cmd_q.h <= req_h[g_q];
        cmd_q.w <= req_w[g_q];
      end
      if (state_q == ST_DONE) begin
        rr_q <= (g_q == ID_W'(NREQ - 1)) ? '0 : g_q + ID_W'(1);
      end
    end
  end

  assign eng_x = cmd_q.x;
  assign eng_y = cmd_q.y;
  assign eng_h = cmd_q.h;
  assign eng_w = cmd_q.w;

  // Ready is also gated to RUN so the engine can never hand over a pixel
  // the FSM would not push, and so every output is low while in reset.
  assign eng_ready = !skid_full && (state_q == ST_RUN);

  assign push_data = '{x: eng_out0, y: eng_out1, id: PIX_ID_W'(g_q)};
  assign pop       = pix_valid && pix_ready;

  draw_rect_sched_skid u_skid (
    ._clock    (_clock),
    ._reset_n  (_reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (skid_full),
    .empty     (skid_empty)
  );

  assign pix_valid = !skid_empty;
  assign pix_x     = head.x;
  assign pix_y     = head.y;
  assign pix_id    = ID_W'(head.id);

`ifdef DRAW_RECT_SCHED_PIXCHECK_EN
  logic [COORD_W-1:0] pix_cnt_q;
  logic [COORD_W-1:0] area;
  logic               err_q;

  assign area = COORD_W'(cmd_q.w * cmd_q.h);

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      pix_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == ST_START) begin
        pix_cnt_q <= '0;
      end else if (push) begin
        pix_cnt_q <= pix_cnt_q + COORD_W'(1);
      end
      if (state_q == ST_DRAIN && state_d == ST_DONE && pix_cnt_q != area) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_draw_rect_scheduler.sv
// Directed bench for draw_rect_scheduler with a behavioural fill-engine model
// (row-major, x inner) and a pixel sink with optional backpressure.
module tb_draw_rect_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned CW   = 32;

  logic                        clk;
  logic                        rst_n;
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][CW-1:0]     req_x, req_y, req_h, req_w;
  logic [NREQ-1:0]             req_done;
  logic                        eng_start;
  logic signed [CW-1:0]        eng_x, eng_y, eng_h, eng_w;
  logic                        eng_valid;
  logic                        eng_ready;
  logic signed [CW-1:0]        eng_out0, eng_out1;
  logic                        eng_done;
  logic                        pix_valid;
  logic                        pix_ready;
  logic signed [CW-1:0]        pix_x, pix_y;
  logic [1:0]                  pix_id;
  logic                        err;

  int checks   = 0;
  int failures = 0;

  // monitor / engine model state
  int  cyc = 0;
  int  ex, ey, ew, eh, cx, cy, emitted, limit;
  bit  eng_active = 0, pend_st = 0, pend_hs = 0, prev_stall = 0;
  bit  bp_mode = 0, short_mode = 0, eng_stall_seen = 0;
  logic [127:0]    held;
  logic [NREQ-1:0] drop_mask = '0;
  int  grant_q[$];
  int  done_q[$];
  logic [65:0] got_q[$];
  int  start_cnt, ready_cyc, done_cyc, start_cyc;
  int  first_hs_cyc, first_pix_cyc, last_pix_cyc, req_cyc;

  draw_rect_scheduler #(.NREQ(NREQ), .COORD_W(CW)) dut (
    ._clock    (clk),
    ._reset_n  (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_h     (req_h),
    .req_w     (req_w),
    .req_done  (req_done),
    .eng_start (eng_start),
    .eng_x     (eng_x),
    .eng_y     (eng_y),
    .eng_h     (eng_h),
    .eng_w     (eng_w),
    .eng_valid (eng_valid),
    .eng_ready (eng_ready),
    .eng_out0  (eng_out0),
    .eng_out1  (eng_out1),
    .eng_done  (eng_done),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_id    (pix_id),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) oh2idx = i;
    end
  endfunction

  function automatic logic [65:0] exp_pix(input int x, input int y, input int id);
    return {x[31:0], y[31:0], id[1:0]};
  endfunction

  // Engine model, pixel sink and event logger. Everything is observed and
  // driven on the falling edge; values seen here are what the DUT samples
  // at the following rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      eng_active = 0;
      eng_valid  = 1'b0;
      eng_done   = 1'b0;
      pend_st    = 0;
      pend_hs    = 0;
      prev_stall = 0;
      drop_mask  = '0;
    end else begin
      req_valid = req_valid & ~drop_mask;

      if (pend_st) begin
        ex = eng_x; ey = eng_y; ew = eng_w; eh = eng_h;
        cx = 0; cy = 0; emitted = 0;
        limit      = short_mode ? ew * eh - 1 : ew * eh;
        eng_active = 1;
        eng_done   = 1'b0;
      end else if (pend_hs) begin
        emitted++;
        if (cx == ew - 1) begin cx = 0; cy++; end
        else cx++;
      end
      if (eng_active && emitted < limit) begin
        eng_valid = 1'b1;
        eng_out0  = ex + cx;
        eng_out1  = ey + cy;
      end else begin
        eng_valid = 1'b0;
        if (eng_active) begin
          eng_done   = 1'b1;
          eng_active = 0;
        end
      end

      pix_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
      if (prev_stall) check("pix_hold", {pix_valid, pix_x, pix_y, pix_id}, held);
      if (pix_valid && pix_ready) begin
        got_q.push_back({pix_x, pix_y, pix_id});
        if (first_pix_cyc < 0) first_pix_cyc = cyc;
        last_pix_cyc = cyc;
      end
      prev_stall = pix_valid && !pix_ready;
      held = {pix_valid, pix_x, pix_y, pix_id};

      if (eng_valid && eng_ready && first_hs_cyc < 0) first_hs_cyc = cyc;
      if (eng_valid && !eng_ready) eng_stall_seen = 1;
      if (eng_start) begin start_cnt++; start_cyc = cyc; end
      if (req_ready != '0) begin grant_q.push_back(oh2idx(req_ready)); ready_cyc = cyc; end
      if (req_done != '0) begin done_q.push_back(oh2idx(req_done)); done_cyc = cyc; end

      drop_mask = req_ready;
      pend_st   = eng_start;
      pend_hs   = eng_valid && eng_ready;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    grant_q.delete(); done_q.delete(); got_q.delete();
    start_cnt = 0; ready_cyc = -1; done_cyc = -1; start_cyc = -1;
    first_hs_cyc = -1; first_pix_cyc = -1; last_pix_cyc = -1;
    eng_stall_seen = 0;
    req_cyc = cyc;
  endtask

  task automatic set_req(input int i, input int x, input int y, input int w, input int h);
    req_x[i] = x; req_y[i] = y; req_w[i] = w; req_h[i] = h;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_done(input int n, input string tag);
    int k;
    k = 0;
    while (done_q.size() < n && k < 500) begin
      step(1);
      k++;
    end
    check(tag, done_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0;
    pix_ready = 1'b0; eng_valid = 1'b0; eng_done = 1'b0;
    eng_out0 = '0; eng_out1 = '0;
    clear_logs();
    step(2);
    check("rst_ctl", {req_ready, req_done, eng_start, eng_ready, pix_valid, err}, '0);
    check("rst_eng_ops", {eng_x, eng_y, eng_h, eng_w}, '0);
    check("rst_pix", {pix_x, pix_y, pix_id}, '0);
    rst_n = 1'b1;
    step(2);

    // all four at once, unit jobs: round robin from 0
    clear_logs();
    for (int i = 0; i < 4; i++) set_req(i, 100 + i, 200 + i, 1, 1);
    wait_done(4, "rr4_done");
    check("rr4_ngrant", grant_q.size(), 4);
    check("rr4_npix", got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("rr4_grant", grant_q[i], i);
      check("rr4_done_id", done_q[i], i);
      check("rr4_pix", got_q[i], exp_pix(100 + i, 200 + i, i));
    end
    step(2);
    clear_logs();
    set_req(0, 1, 1, 1, 1);
    set_req(2, 3, 3, 1, 1);
    wait_done(2, "rr02_done");
    check("rr02_first", grant_q[0], 0);
    check("rr02_second", grant_q[1], 2);
    step(2);
    clear_logs();
    set_req(1, 1, 1, 1, 1);
    set_req(3, 3, 3, 1, 1);
    wait_done(2, "rr_wrap_done");
    check("rr_wrap_first", grant_q[0], 3);
    check("rr_wrap_second", grant_q[1], 1);
    step(2);

    // single 2x3 job at (10,20) from requester 0
    clear_logs();
    set_req(0, 10, 20, 2, 3);
    wait_done(1, "t1_done");
    step(3);
    check("t1_starts", start_cnt, 1);
    check("t1_ngrant", grant_q.size(), 1);
    check("t1_grant", grant_q[0], 0);
    check("t1_done_id", done_q[0], 0);
    check("t1_ready_lat", ready_cyc - req_cyc, 2);
    check("t1_start_lat", start_cyc - ready_cyc, 1);
    check("t1_pix_lat", first_pix_cyc - first_hs_cyc, 1);
    check("t1_thruput", last_pix_cyc - first_pix_cyc, 5);
    check("t1_npix", got_q.size(), 6);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 2; c++)
        check("t1_pix", got_q[r * 2 + c], exp_pix(10 + c, 20 + r, 0));
    check("t1_done_after_pix", done_cyc > last_pix_cyc, 1);
    check("t1_err", err, 0);

    // 4x4 job under 1-of-3 pixel backpressure
    clear_logs();
    bp_mode = 1;
    set_req(1, 5, 7, 4, 4);
    wait_done(1, "bp_done");
    bp_mode = 0;
    step(2);
    check("bp_npix", got_q.size(), 16);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check("bp_pix", got_q[r * 4 + c], exp_pix(5 + c, 7 + r, 1));
    check("bp_eng_stall", eng_stall_seen, 1);
    check("bp_done_id", done_q[0], 1);

    // degenerate commands: zero width, negative height
    clear_logs();
    set_req(1, 0, 0, 0, 5);
    wait_done(1, "deg0_done");
    step(3);
    check("deg0_grant", grant_q[0], 1);
    check("deg0_ready_to_done", done_cyc - ready_cyc, 1);
    check("deg0_starts", start_cnt, 0);
    check("deg0_npix", got_q.size(), 0);
    clear_logs();
    set_req(2, 0, 0, 3, -1);
    wait_done(1, "degneg_done");
    step(3);
    check("degneg_grant", grant_q[0], 2);
    check("degneg_ready_to_done", done_cyc - ready_cyc, 1);
    check("degneg_starts", start_cnt, 0);
    check("degneg_npix", got_q.size(), 0);

    // reset in the middle of a job
    clear_logs();
    set_req(3, 0, 0, 4, 4);
    for (int k = 0; k < 200 && got_q.size() < 3; k++) step(1);
    check("mid_started", got_q.size() >= 3, 1);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    check("mid_rst_ctl", {req_ready, req_done, eng_start, eng_ready, pix_valid, err}, '0);
    check("mid_rst_eng", {eng_x, eng_y, eng_h, eng_w}, '0);
    check("mid_rst_pix", {pix_x, pix_y, pix_id}, '0);
    step(2);
    clear_logs();
    rst_n = 1'b1;
    step(6);
    check("mid_no_done", done_q.size(), 0);
    check("mid_no_pix", got_q.size(), 0);
    check("mid_no_start", start_cnt, 0);
    set_req(3, 9, 9, 1, 1);
    set_req(0, 8, 8, 1, 1);
    wait_done(2, "post_rst_done");
    check("post_rst_first", grant_q[0], 0);
    check("post_rst_second", grant_q[1], 3);
    step(2);

    // engine emits one pixel short of w*h, then a correct job
    clear_logs();
    short_mode = 1;
    set_req(0, 1, 1, 2, 3);
    wait_done(1, "short_done");
    short_mode = 0;
    step(2);
    check("short_npix", got_q.size(), 5);
`ifdef DRAW_RECT_SCHED_PIXCHECK_EN
    check("short_err", err, 1);
`else
    check("short_err", err, 0);
`endif
    clear_logs();
    set_req(1, 0, 0, 1, 2);
    wait_done(1, "ok_done");
    step(2);
    check("ok_npix", got_q.size(), 2);
`ifdef DRAW_RECT_SCHED_PIXCHECK_EN
    check("err_sticky", err, 1);
`else
    check("err_sticky", err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
